// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STAT window, byte FIFO, serializer.
// Read data is registered (one cycle); pushes to a full FIFO are dropped and flagged in ovf.
module uart_tx_mmio #(
   parameter logic [15:0] BASE_ADDR = 16'hFF00,
   parameter int          CLKDIV    = 16,
   parameter int          DEPTH     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] mem_waddr_i,
   input  logic [15:0] mem_wdata_i,
   input  logic        mem_wr_i,
   input  logic [15:0] mem_raddr_i,
   input  logic        mem_rd_i,
   output logic [15:0] io_rdata_o,
   output logic        io_sel_o,
   output logic        txd_o
);
   localparam int          AW        = $clog2(DEPTH);
   localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
   localparam logic [15:0] RELOAD    = 16'(CLKDIV - 1);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          r_ovf;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [15:0]   r_timer;
   logic [15:0]   w_timer_nxt;
   logic [2:0]    r_bit;
   logic [2:0]    w_bit_nxt;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_nxt;
   logic          r_txd;
   logic          w_txd_nxt;
   logic [15:0]   r_rdata;
   logic          r_sel;

   logic          w_wr_data;
   logic          w_rd_data;
   logic          w_rd_stat;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_busy;
   logic [15:0]   w_cnt16;

   assign w_wr_data = mem_wr_i && (mem_waddr_i == BASE_ADDR);
   assign w_rd_data = mem_rd_i && (mem_raddr_i == BASE_ADDR);
   assign w_rd_stat = mem_rd_i && (mem_raddr_i == STAT_ADDR);
   assign w_full    = (r_count == FULL_CNT);
   // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
   assign w_push    = w_wr_data && !w_full;
   assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
   assign w_busy    = (r_state != S_IDLE) || (r_count != '0);
   assign w_cnt16   = 16'(r_count);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= mem_wdata_i[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_sel   <= 1'b0;
         r_rdata <= 16'h0000;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_wr_data && w_full) r_ovf <= 1'b1;
         else if (w_rd_stat)      r_ovf <= 1'b0;
         r_sel   <= w_rd_data || w_rd_stat;
         r_rdata <= w_rd_data ? {8'h00, w_cnt16[7:0]} :
                    w_rd_stat ? {13'b0, r_ovf, w_busy, w_full} : 16'h0000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_timer <= 16'h0000;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
         r_txd   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_txd   <= w_txd_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      case (r_state)
         S_IDLE: begin
            if (w_pop) begin
               w_state_nxt = S_START;
               w_timer_nxt = RELOAD;
               w_shift_nxt = r_mem[r_rptr];
            end
         end
         S_START: begin
            if (r_timer == 16'h0000) begin
               w_state_nxt = S_DATA;
               w_timer_nxt = RELOAD;
               w_bit_nxt   = 3'd0;
            end else begin
               w_timer_nxt = r_timer - 16'd1;
            end
         end
         S_DATA: begin
            if (r_timer == 16'h0000) begin
               w_timer_nxt = RELOAD;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
               end
            end else begin
               w_timer_nxt = r_timer - 16'd1;
            end
         end
         S_STOP: begin
            if (r_timer == 16'h0000) begin
               w_state_nxt = S_IDLE;
               w_timer_nxt = RELOAD;
            end else begin
               w_timer_nxt = r_timer - 16'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Line level follows the state being entered, so txd_o is a flop aligned with r_state.
   always_comb begin
      w_txd_nxt = 1'b1;
      case (w_state_nxt)
         S_START: w_txd_nxt = 1'b0;
         S_DATA:  w_txd_nxt = w_shift_nxt[0];
         default: w_txd_nxt = 1'b1;
      endcase
   end

   assign txd_o      = r_txd;
   assign io_sel_o   = r_sel;
   assign io_rdata_o = r_rdata;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: table-driven register accesses plus serial-frame scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
   localparam int          CLKDIV = 4;
   localparam int          DEPTH  = 8;
   localparam logic [15:0] BASE   = 16'hFF00;
   localparam logic [15:0] STAT   = 16'hFF01;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] mem_waddr_i = 16'h0;
   logic [15:0] mem_wdata_i = 16'h0;
   logic        mem_wr_i = 1'b0;
   logic [15:0] mem_raddr_i = 16'h0;
   logic        mem_rd_i = 1'b0;
   logic [15:0] io_rdata_o;
   logic        io_sel_o;
   logic        txd_o;

   always #5 clk = ~clk;

   uart_tx_mmio #(.BASE_ADDR(BASE), .CLKDIV(CLKDIV), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i), .mem_wr_i(mem_wr_i),
      .mem_raddr_i(mem_raddr_i), .mem_rd_i(mem_rd_i),
      .io_rdata_o(io_rdata_o), .io_sel_o(io_sel_o), .txd_o(txd_o)
   );

   typedef struct {
      logic        sel;
      logic [15:0] data;
   } rd_exp_t;

   typedef struct {
      logic        wr;
      logic [15:0] waddr;
      logic [15:0] wdata;
      logic        rd;
      logic [15:0] raddr;
      logic        exp_sel;
      logic [15:0] exp_data;
      logic        acc;
   } vec_t;

   rd_exp_t    rd_q[$];
   logic [7:0] byte_q[$];
   int         start_q[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic       mon_act = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_byte = 8'h00;
   vec_t       tbl[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      mem_wr_i = 1'b1; mem_waddr_i = a; mem_wdata_i = d;
   endtask

   task automatic rd(input logic [15:0] a, input logic s, input logic [15:0] d);
      rd_exp_t e;
      mem_rd_i = 1'b1; mem_raddr_i = a;
      e.sel = s; e.data = d;
      rd_q.push_back(e);
   endtask

   // One clock: inputs sampled at posedge, outputs checked at the following negedge.
   task automatic step();
      rd_exp_t e;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (rd_q.size() != 0) begin
         e = rd_q.pop_front();
         chk("rd_sel", {63'b0, io_sel_o}, {63'b0, e.sel});
         chk("rd_data", {48'b0, io_rdata_o}, {48'b0, e.data});
      end else if (io_sel_o !== 1'b0) begin
         checks++; failures++;
         $display("FAIL rd_sel_spurious actual=%b required=0", io_sel_o);
      end
      if (!mon_act) begin
         if (txd_o === 1'b0) begin
            mon_act = 1'b1; mon_cnt = 0; start_q.push_back(cyc);
         end
      end else begin
         mon_cnt++;
         if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt - 6) % 4 == 0)
            mon_byte[(mon_cnt - 6) / 4] = txd_o;
         if (mon_cnt == 38) begin
            chk("uart_stop", {63'b0, txd_o}, 64'd1);
            if (byte_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL uart_unexpected_byte actual=%0h required=none", mon_byte);
            end else begin
               chk("uart_byte", {56'b0, mon_byte}, {56'b0, byte_q.pop_front()});
            end
            mon_act = 1'b0;
         end
      end
      mem_wr_i = 1'b0; mem_rd_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((byte_q.size() != 0 || mon_act) && n < 3000) begin
         step(); n++;
      end
      chk("drain_done", {63'b0, (n < 3000)}, 64'd1);
      repeat (4) step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [40:0] act_bits;
      logic [40:0] exp_bits;
      int          lows;

      tbl[0]  = '{1'b1, BASE,     16'h12A1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
      tbl[1]  = '{1'b1, BASE,     16'h00A2, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
      tbl[2]  = '{1'b1, BASE,     16'hFFA3, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
      tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, BASE,     1'b1, 16'h0002, 1'b0};
      tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, STAT,     1'b1, 16'h0002, 1'b0};
      tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFF02, 1'b0, 16'h0000, 1'b0};
      tbl[7]  = '{1'b1, STAT,     16'h00EE, 1'b1, BASE,     1'b1, 16'h0002, 1'b0};
      tbl[8]  = '{1'b1, 16'hFF02, 16'h00EF, 1'b1, 16'hFEFF, 1'b0, 16'h0000, 1'b0};
      tbl[9]  = '{1'b1, BASE,     16'h00A4, 1'b1, BASE,     1'b1, 16'h0002, 1'b1};
      tbl[10] = '{1'b0, 16'h0000, 16'h0000, 1'b1, BASE,     1'b1, 16'h0003, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_txd", {63'b0, txd_o}, 64'd1);
      chk("rst_sel", {63'b0, io_sel_o}, 64'd0);
      chk("rst_rdata", {48'b0, io_rdata_o}, 64'd0);
      rst_n = 1'b1;
      rd(STAT, 1'b1, 16'h0000); step();
      rd(BASE, 1'b1, 16'h0000); step();

      // Decode, occupancy and simultaneous read/write
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].wr) wr(tbl[i].waddr, tbl[i].wdata);
         if (tbl[i].rd) rd(tbl[i].raddr, tbl[i].exp_sel, tbl[i].exp_data);
         if (tbl[i].acc) byte_q.push_back(tbl[i].wdata[7:0]);
         step();
      end
      drain();
      rd(STAT, 1'b1, 16'h0000); step();

      // Exact line waveform for one byte; high byte of the write is ignored
      wr(BASE, 16'h1255); byte_q.push_back(8'h55); step();
      act_bits[0] = txd_o;
      exp_bits[0] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         step();
         act_bits[c+1] = txd_o;
         if (c < 4)       exp_bits[c+1] = 1'b0;
         else if (c < 36) exp_bits[c+1] = 1'(8'h55 >> ((c - 4) / 4));
         else             exp_bits[c+1] = 1'b1;
      end
      chk("frame_waveform", {23'b0, act_bits}, {23'b0, exp_bits});
      drain();

      // Burst of 10 writes: 1 popped, 8 queued, 1 dropped
      for (int i = 0; i < 10; i++) begin
         wr(BASE, 16'(8'h30 + i));
         if (i < 9) byte_q.push_back(8'(8'h30 + i));
         step();
      end
      rd(STAT, 1'b1, 16'h0007); step();
      rd(STAT, 1'b1, 16'h0003); step();
      drain();
      rd(STAT, 1'b1, 16'h0000); step();

      // Push into full FIFO on the serializer pop edge; also frame spacing
      start_q.delete();
      for (int i = 0; i < 9; i++) begin
         wr(BASE, 16'(8'hC0 + i)); byte_q.push_back(8'(8'hC0 + i)); step();
      end
      repeat (33) step();
      wr(BASE, 16'h00EE); step();
      rd(STAT, 1'b1, 16'h0006); step();
      rd(BASE, 1'b1, 16'h0007); step();
      chk("frame_period", (start_q.size() >= 2) ? 64'(start_q[1] - start_q[0]) : 64'hFFFF, 64'd41);
      drain();

      // Reset during data bit 3
      wr(BASE, 16'h0000); byte_q.push_back(8'h00); step();
      wr(BASE, 16'h00FF); byte_q.push_back(8'hFF); step();
      repeat (17) step();
      chk("pre_rst_txd", {63'b0, txd_o}, 64'd0);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_txd", {63'b0, txd_o}, 64'd1);
      chk("async_rst_sel", {63'b0, io_sel_o}, 64'd0);
      byte_q.delete(); rd_q.delete(); mon_act = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd(STAT, 1'b1, 16'h0000); step();
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (txd_o !== 1'b1) lows++;
      end
      chk("no_frame_after_rst", 64'(lows), 64'd0);

      // First push after a fresh reset release is taken on the first edge
      rst_n = 1'b0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wr(BASE, 16'h005A); byte_q.push_back(8'h5A); step();
      rd(BASE, 1'b1, 16'h0001); step();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
